// File: rtl/flexka_buffer_ram_r4w1.sv
// ---------------------------------------------------------------------------
// flexka_buffer_ram_r4w1
//
// Purpose
//   C-stack buffer RAM with four independent synchronous read ports and one
//   write port. Partial-product combination and the other stack users read it.
//   Read data appears a fixed LATENCY cycles after the address. The
//   requester's read_valid travels down a matching shift register, so that
//   consumers can align their zero/first/end flags with the data.
//
// Parameters
//   FSIZE    word width of the stored data and of each rdata port (<= BUF_FSIZE)
//   DEPTH    number of words; AW = $clog2(DEPTH) address bits (<= BUF_AW)
//   LATENCY  read latency in cycles, >= 1
//
// Ports
//   clk                      in   single clock, posedge
//   rst                      in   asynchronous, active-high reset
//   Mem_C_inputs             in   raddr0..3, waddr, wdata, wren (request struct)
//   Mem_C_inputs_read_valid  in   marks this cycle's read addresses as meaningful
//   Mem_C_outputs_rdata0..3  out  read data for raddr0..3
//   Mem_C_outputs_rvalid     out  read_valid delayed by LATENCY cycles
//   Mem_C_oob_err            out  sticky: an out-of-range access was seen
//
// Configuration
//   FLEXKA_BUFFER_RAM_BYPASS_EN  defined:   write-first. A read that hits the
//                                           address being written in the same
//                                           cycle returns the new wdata.
//                                undefined: read-first. The old word is
//                                           returned, and the read path has no
//                                           forwarding mux.
// ---------------------------------------------------------------------------

package flexka_buffer_ram_pkg;

    // Field widths of the request struct. They are sized for the widest
    // buffer in use. A narrower instance uses only the low bits of wdata and
    // the low AW bits of each address.
    localparam int BUF_AW    = 8;
    localparam int BUF_FSIZE = 64;

    typedef struct packed {
        logic [BUF_AW-1:0]    raddr0;
        logic [BUF_AW-1:0]    raddr1;
        logic [BUF_AW-1:0]    raddr2;
        logic [BUF_AW-1:0]    raddr3;
        logic [BUF_AW-1:0]    waddr;
        logic [BUF_FSIZE-1:0] wdata;
        logic                 wren;
    } buffer_ram_tfsize_inputs_r4w1_t;

endpackage

module flexka_buffer_ram_r4w1
    import flexka_buffer_ram_pkg::*;
#(
    parameter int FSIZE   = 64,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  buffer_ram_tfsize_inputs_r4w1_t Mem_C_inputs,
    input  logic                           Mem_C_inputs_read_valid,
    output logic [FSIZE-1:0]               Mem_C_outputs_rdata0,
    output logic [FSIZE-1:0]               Mem_C_outputs_rdata1,
    output logic [FSIZE-1:0]               Mem_C_outputs_rdata2,
    output logic [FSIZE-1:0]               Mem_C_outputs_rdata3,
    output logic                           Mem_C_outputs_rvalid,
    output logic                           Mem_C_oob_err
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // A power-of-two depth cannot be addressed out of range, so no range
    // checking is done for it.
    localparam bit POW2 = (DEPTH == (1 << AW));
    // DEPTH at one bit wider than an address field, so that the compare
    // cannot overflow.
    localparam logic [BUF_AW:0] DEPTH_W = (BUF_AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [FSIZE-1:0] mem [DEPTH];

    logic [3:0][BUF_AW-1:0] raddr;
    logic [FSIZE-1:0]       wdata;
    logic                   wr_oob;
    logic                   wr_en;

    assign raddr  = {Mem_C_inputs.raddr3, Mem_C_inputs.raddr2,
                     Mem_C_inputs.raddr1, Mem_C_inputs.raddr0};
    // Any wdata bits above FSIZE are discarded.
    assign wdata  = Mem_C_inputs.wdata[FSIZE-1:0];
    assign wr_oob = !POW2 && ({1'b0, Mem_C_inputs.waddr} >= DEPTH_W);
    // An out-of-range write is dropped. It still raises oob_err.
    assign wr_en  = Mem_C_inputs.wren && !wr_oob;

    // NOTE: the storage array has no reset. A RAM macro cannot be cleared in
    // one cycle, and its contents must survive rst. The write process
    // therefore stays separate from the reset pipeline below.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[Mem_C_inputs.waddr[AW-1:0]] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Stage-1 read: the array sample, plus an optional write-first forward
    // ------------------------------------------------------------------
    logic [3:0][FSIZE-1:0] rd_word;
    logic [3:0]            rd_oob;

    // NOTE: every variable assigned in this block gets a default first. A
    // path that skips an assignment would otherwise infer a latch.
    always_comb begin
        rd_word = '0;
        rd_oob  = '0;
        for (int p = 0; p < 4; p++) begin
            rd_oob[p] = !POW2 && ({1'b0, raddr[p]} >= DEPTH_W);
            // An out-of-range read returns zero and never indexes past the array.
            if (!rd_oob[p]) begin
                rd_word[p] = mem[raddr[p][AW-1:0]];
            end
`ifdef FLEXKA_BUFFER_RAM_BYPASS_EN
            // wr_en already implies an in-range waddr. The address match
            // therefore also implies an in-range raddr.
            if (wr_en && (raddr[p] == Mem_C_inputs.waddr)) begin
                rd_word[p] = wdata;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Stage 0 holds the array sample; later stages are pure
    // delay. Reset flushes both the data and the valids.
    // ------------------------------------------------------------------
    logic [3:0][FSIZE-1:0] data_pipe  [LATENCY];
    logic                  valid_pipe [LATENCY];
    logic                  oob_err;

    // NOTE: state is updated with non-blocking assignments. Every stage then
    // sees the value its predecessor held before the edge, and no stage is
    // skipped within a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_pipe[i]  <= '0;
                valid_pipe[i] <= 1'b0;
            end
            oob_err <= 1'b0;
        end else begin
            data_pipe[0]  <= rd_word;
            valid_pipe[0] <= Mem_C_inputs_read_valid;
            for (int i = 1; i < LATENCY; i++) begin
                data_pipe[i]  <= data_pipe[i-1];
                valid_pipe[i] <= valid_pipe[i-1];
            end
            // Every port reads on every cycle, so a stray read address counts
            // even while read_valid is low.
            if ((|rd_oob) || (Mem_C_inputs.wren && wr_oob)) begin
                oob_err <= 1'b1;
            end
        end
    end

    assign Mem_C_outputs_rdata0 = data_pipe[LATENCY-1][0];
    assign Mem_C_outputs_rdata1 = data_pipe[LATENCY-1][1];
    assign Mem_C_outputs_rdata2 = data_pipe[LATENCY-1][2];
    assign Mem_C_outputs_rdata3 = data_pipe[LATENCY-1][3];
    assign Mem_C_outputs_rvalid = valid_pipe[LATENCY-1];
    assign Mem_C_oob_err        = oob_err;

endmodule

// File: tb/tb_flexka_buffer_ram_r4w1.sv
// ---------------------------------------------------------------------------
// tb_flexka_buffer_ram_r4w1
//
// Bench for flexka_buffer_ram_r4w1, instantiated with DEPTH=200 so that range
// checking is active.
//
// Every read issued with read_valid=1 pushes its hand-computed words, and the
// cycle in which they are due, onto a scoreboard. A separate monitor runs on
// the falling edge. Whenever rvalid is high, it pops the head entry and
// compares the data and the arrival cycle.
// ---------------------------------------------------------------------------

module tb_flexka_buffer_ram_r4w1;
    import flexka_buffer_ram_pkg::*;

    localparam int FS  = 64;
    localparam int DEP = 200;
    localparam int LAT = 2;

`ifdef FLEXKA_BUFFER_RAM_BYPASS_EN
    localparam logic [63:0] RDW_EXP = 64'hBEEF;
`else
    localparam logic [63:0] RDW_EXP = 64'hAAAA;
`endif

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    buffer_ram_tfsize_inputs_r4w1_t mem_in = '0;
    logic                           read_valid = 1'b0;
    logic [3:0][FS-1:0]             rdata;
    logic                           rvalid;
    logic                           oob_err;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string             name;
        logic [3:0]        mask;
        logic [3:0][63:0]  data;
        int                due;
    } exp_t;

    exp_t sb[$];

    flexka_buffer_ram_r4w1 #(.FSIZE(FS), .DEPTH(DEP), .LATENCY(LAT)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .Mem_C_inputs            (mem_in),
        .Mem_C_inputs_read_valid (read_valid),
        .Mem_C_outputs_rdata0    (rdata[0]),
        .Mem_C_outputs_rdata1    (rdata[1]),
        .Mem_C_outputs_rdata2    (rdata[2]),
        .Mem_C_outputs_rdata3    (rdata[3]),
        .Mem_C_outputs_rvalid    (rvalid),
        .Mem_C_oob_err           (oob_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called in the cycle the read is driven. The data is due LAT edges later.
    task automatic expect_rd(input string name, input logic [3:0] mask,
                             input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3);
        exp_t e;
        e.name = name;
        e.mask = mask;
        e.data = {d3, d2, d1, d0};
        e.due  = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid: actual rvalid=1 at cycle %0d, required 0", cyc);
        end else begin
            e = sb.pop_front();
            check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
            for (int p = 0; p < 4; p++) begin
                if (e.mask[p]) begin
                    check($sformatf("%s_port%0d", e.name, p), rdata[p], e.data[p]);
                end
            end
        end
    endtask

    // Monitor: decoupled from the stimulus, it samples on the falling edge.
    always @(negedge clk) begin
        if (!rst && rvalid) compare_head();
    end

    // Advance to the next cycle and return all inputs to idle.
    task automatic step();
        @(posedge clk);
        #1;
        mem_in     = '0;
        read_valid = 1'b0;
    endtask

    task automatic write_word(input logic [7:0] a, input logic [63:0] d);
        step();
        mem_in.waddr = a;
        mem_in.wdata = d;
        mem_in.wren  = 1'b1;
    endtask

    task automatic read4(input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3);
        mem_in.raddr0 = a0;
        mem_in.raddr1 = a1;
        mem_in.raddr2 = a2;
        mem_in.raddr3 = a3;
        read_valid    = 1'b1;
    endtask

    initial begin
        // Reset state, sampled while rst is still asserted.
        repeat (2) @(posedge clk);
        #1;
        check("rst_rvalid", 64'(rvalid), 64'd0);
        for (int p = 0; p < 4; p++) check($sformatf("rst_rdata%0d", p), rdata[p], 64'd0);
        check("rst_oob_err", 64'(oob_err), 64'd0);
        rst = 1'b0;

        // Reverse-order read across the four ports.
        write_word(8'd0, 64'h1111);
        write_word(8'd1, 64'h2222);
        write_word(8'd2, 64'h3333);
        write_word(8'd3, 64'h4444);
        step();
        read4(8'd3, 8'd2, 8'd1, 8'd0);
        expect_rd("reverse", 4'hF, 64'h4444, 64'h3333, 64'h2222, 64'h1111);

        // Streaming read with read_valid held high for 5 cycles.
        for (int i = 0; i < 5; i++) write_word(8'(10 + i), 64'(10 + i));
        for (int i = 0; i < 5; i++) begin
            step();
            read4(8'(10 + i), 8'd0, 8'd0, 8'd0);
            expect_rd($sformatf("stream%0d", i), 4'h1, 64'(10 + i), 0, 0, 0);
        end

        // Read-during-write to the same address, then the follow-up read.
        write_word(8'd7, 64'hAAAA);
        step();
        mem_in.waddr = 8'd7;
        mem_in.wdata = 64'hBEEF;
        mem_in.wren  = 1'b1;
        read4(8'd0, 8'd7, 8'd0, 8'd0);
        expect_rd("rdw_same", 4'h2, 0, RDW_EXP, 0, 0);
        step();
        read4(8'd0, 8'd7, 8'd0, 8'd0);
        expect_rd("rdw_next", 4'h2, 0, 64'hBEEF, 0, 0);

        // All four ports on one address, with a concurrent write elsewhere.
        write_word(8'd5, 64'h5555);
        write_word(8'd6, 64'h6666);
        step();
        read4(8'd5, 8'd5, 8'd5, 8'd5);
        mem_in.waddr = 8'd6;
        mem_in.wdata = 64'h6006;
        mem_in.wren  = 1'b1;
        expect_rd("same_addr", 4'hF, 64'h5555, 64'h5555, 64'h5555, 64'h5555);
        step();
        read4(8'd6, 8'd0, 8'd0, 8'd0);
        expect_rd("addr6_upd", 4'h1, 64'h6006, 0, 0, 0);

        // Range checking: 199 is the last legal address, and 200 is the first
        // illegal one.
        write_word(8'd20, 64'h2020);
        write_word(8'd92, 64'h9292);
        write_word(8'd199, 64'h1990);
        step();
        check("oob_before", 64'(oob_err), 64'd0);
        read4(8'd199, 8'd5, 8'd0, 8'd0);
        expect_rd("last_addr", 4'h1, 64'h1990, 64'h5555, 0, 0);
        step();
        read4(8'd200, 8'd5, 8'd250, 8'd199);
        mem_in.waddr = 8'd220;
        mem_in.wdata = 64'hDEAD;
        mem_in.wren  = 1'b1;
        expect_rd("oob_read", 4'hF, 64'd0, 64'h5555, 64'd0, 64'h1990);
        step();
        check("oob_set", 64'(oob_err), 64'd1);
        read4(8'd20, 8'd92, 8'd199, 8'd0);
        expect_rd("oob_nowrite", 4'hF, 64'h2020, 64'h9292, 64'h1990, 64'h1111);
        repeat (3) step();
        check("oob_sticky", 64'(oob_err), 64'd1);

        // Reset while two reads are in flight.
        step();
        read4(8'd3, 8'd2, 8'd1, 8'd0);
        step();
        read4(8'd0, 8'd1, 8'd2, 8'd3);
        @(posedge clk);
        #1;
        check("inflight_rvalid", 64'(rvalid), 64'd1);
        check("inflight_rdata0", rdata[0], 64'h4444);
        #1;
        rst = 1'b1;
        #1;
        check("async_rvalid", 64'(rvalid), 64'd0);
        for (int p = 0; p < 4; p++) check($sformatf("async_rdata%0d", p), rdata[p], 64'd0);
        check("async_oob_clr", 64'(oob_err), 64'd0);
        mem_in     = '0;
        read_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        // Read issued in the first cycle after reset deassertion.
        read4(8'd0, 8'd1, 8'd2, 8'd3);
        expect_rd("post_rst_a", 4'hF, 64'h1111, 64'h2222, 64'h3333, 64'h4444);
        step();
        read4(8'd7, 8'd10, 8'd14, 8'd6);
        expect_rd("post_rst_b", 4'hF, 64'hBEEF, 64'd10, 64'd14, 64'h6006);
        step();

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
